// File: rtl/spi_master_pkg.sv
// Shared definitions for the APB SPI master engines: word and counter
// widths, the receive FSM state encoding and the receive shift helper.
package spi_master_pkg;

    localparam int unsigned SPI_WORD_W = 32;
    localparam int unsigned SPI_CNT_W  = 16;

    // Default transfer length (in bits) after reset.
    localparam logic [SPI_CNT_W-1:0] SPI_CNT_RST = 16'h8;

    typedef enum logic [1:0] {
        RX_IDLE           = 2'd0,
        RX_RECEIVE        = 2'd1,
        RX_WAIT_FIFO      = 2'd2,
        RX_WAIT_FIFO_DONE = 2'd3
    } rx_state_e;

    // Shift one sample into the receive word. Standard mode takes MISO
    // (sdi[1]); quad mode takes the whole nibble with sdi[3] as its MSB.
    function automatic logic [SPI_WORD_W-1:0] rx_shift(
        input logic [SPI_WORD_W-1:0] word,
        input logic                  quad,
        input logic [3:0]            sdi
    );
        logic [SPI_WORD_W-1:0] res;
        if (quad) begin
            res = {word[SPI_WORD_W-5:0], sdi};
        end else begin
            res = {word[SPI_WORD_W-2:0], sdi[1]};
        end
        return res;
    endfunction

endpackage

// File: rtl/spi_master_rx.sv
// SPI master receive engine: shifts MISO (or four quad lanes) into 32-bit
// words and hands each completed word to the RX FIFO over valid/ready.
// SCK is requested through clk_en_o and dropped while the FIFO stalls, so
// no sample is ever taken while a word is still waiting to be accepted.
module spi_master_rx
    import spi_master_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  rx_edge,
    output logic                  rx_done,
    input  logic                  sdi0,
    input  logic                  sdi1,
    input  logic                  sdi2,
    input  logic                  sdi3,
    input  logic                  en_quad_in,
    input  logic [SPI_CNT_W-1:0]  counter_in,
    input  logic                  counter_in_upd,
    output logic [SPI_WORD_W-1:0] data,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  clk_en_o
);

    rx_state_e              state_r;
    rx_state_e              state_next_s;
    logic [SPI_CNT_W-1:0]   counter_r;
    logic [SPI_CNT_W-1:0]   counter_next_s;
    logic [SPI_CNT_W-1:0]   counter_trgt_r;
    logic [SPI_WORD_W-1:0]  data_int_r;
    logic [SPI_WORD_W-1:0]  data_int_next_s;
    logic [SPI_WORD_W-1:0]  data_shift_s;
    logic                   done_s;
    logic                   reg_done_s;

    // Transfer-end and word-boundary detection; edges outside RECEIVE never count.
    always_comb begin
        data_shift_s = rx_shift(data_int_r, en_quad_in, {sdi3, sdi2, sdi1, sdi0});
        done_s       = (state_r == RX_RECEIVE) && rx_edge &&
                       (counter_r == (counter_trgt_r - 16'd1));
        if (en_quad_in) begin
            reg_done_s = (counter_r[2:0] == 3'h7);
        end else begin
            reg_done_s = (counter_r[4:0] == 5'h1F);
        end
    end

    assign rx_done = done_s;

    // Next-state, counter, shift register and handshake outputs.
    always_comb begin
        state_next_s    = state_r;
        counter_next_s  = counter_r;
        data_int_next_s = data_int_r;
        data            = data_int_r;
        data_valid      = 1'b0;
        clk_en_o        = 1'b0;

        case (state_r)
            RX_IDLE: begin
                if (en) begin
                    state_next_s    = RX_RECEIVE;
                    counter_next_s  = 16'd0;
                    data_int_next_s = 32'd0;
                end else begin
                    state_next_s    = RX_IDLE;
                end
            end

            RX_RECEIVE: begin
                clk_en_o = 1'b1;
                if (rx_edge) begin
                    // The completed word is presented in the same cycle as its last sample.
                    data            = data_shift_s;
                    data_int_next_s = data_shift_s;
                    if (done_s) begin
                        counter_next_s = 16'd0;
                        data_valid     = 1'b1;
                        if (data_ready) begin
                            state_next_s    = RX_IDLE;
                            data_int_next_s = 32'd0;
                        end else begin
                            clk_en_o     = 1'b0;
                            state_next_s = RX_WAIT_FIFO_DONE;
                        end
                    end else if (reg_done_s) begin
                        counter_next_s = counter_r + 16'd1;
                        data_valid     = 1'b1;
                        if (data_ready) begin
                            // Clearing here keeps a short final word right-aligned.
                            data_int_next_s = 32'd0;
                        end else begin
                            clk_en_o     = 1'b0;
                            state_next_s = RX_WAIT_FIFO;
                        end
                    end else begin
                        counter_next_s = counter_r + 16'd1;
                    end
                end else begin
                    state_next_s = RX_RECEIVE;
                end
            end

            RX_WAIT_FIFO: begin
                data_valid = 1'b1;
                if (data_ready) begin
                    state_next_s    = RX_RECEIVE;
                    data_int_next_s = 32'd0;
                end else begin
                    state_next_s    = RX_WAIT_FIFO;
                end
            end

            RX_WAIT_FIFO_DONE: begin
                data_valid = 1'b1;
                if (data_ready) begin
                    state_next_s    = RX_IDLE;
                    data_int_next_s = 32'd0;
                end else begin
                    state_next_s    = RX_WAIT_FIFO_DONE;
                end
            end

            default: begin
                state_next_s    = RX_IDLE;
                counter_next_s  = 16'd0;
                data_int_next_s = 32'd0;
            end
        endcase
    end

    // FSM state, bit counter and shift register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= RX_IDLE;
            counter_r  <= 16'd0;
            data_int_r <= 32'd0;
        end else begin
            state_r    <= state_next_s;
            counter_r  <= counter_next_s;
            data_int_r <= data_int_next_s;
        end
    end

    // Transfer length target; quad mode counts nibbles rather than bits.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            counter_trgt_r <= SPI_CNT_RST;
        end else if (counter_in_upd) begin
            if (en_quad_in) begin
                counter_trgt_r <= {2'b00, counter_in[SPI_CNT_W-1:2]};
            end else begin
                counter_trgt_r <= counter_in;
            end
        end else begin
            counter_trgt_r <= counter_trgt_r;
        end
    end

endmodule

// File: tb/tb_spi_master_rx.sv
// Directed testbench for spi_master_rx: standard, quad, partial word,
// backpressure mid-transfer and at the final word, and reset mid-word.
module tb_spi_master_rx;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        rx_edge;
    logic        rx_done;
    logic        sdi0, sdi1, sdi2, sdi3;
    logic        en_quad_in;
    logic [15:0] counter_in;
    logic        counter_in_upd;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ready;
    logic        clk_en_o;

    int checks   = 0;
    int failures = 0;

    logic        obs_valid;
    logic [31:0] obs_data;
    logic        obs_done;
    logic        obs_ce;

    always #5 clk = ~clk;

    spi_master_rx dut (
        .clk            (clk),
        .rstn           (rstn),
        .en             (en),
        .rx_edge        (rx_edge),
        .rx_done        (rx_done),
        .sdi0           (sdi0),
        .sdi1           (sdi1),
        .sdi2           (sdi2),
        .sdi3           (sdi3),
        .en_quad_in     (en_quad_in),
        .counter_in     (counter_in),
        .counter_in_upd (counter_in_upd),
        .data           (data),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .clk_en_o       (clk_en_o)
    );

    // Standard-mode lanes: MISO on sdi1, the opposite level on the others.
    function automatic logic [3:0] std_nib(input logic b);
        return {~b, ~b, b, ~b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle with rx_edge high; outputs captured at the falling edge.
    task automatic drive_edge(input logic [3:0] nib, input logic rdy);
        {sdi3, sdi2, sdi1, sdi0} = nib;
        rx_edge    = 1'b1;
        data_ready = rdy;
        @(negedge clk);
        obs_valid = data_valid;
        obs_data  = data;
        obs_done  = rx_done;
        obs_ce    = clk_en_o;
        tick();
        rx_edge = 1'b0;
    endtask

    task automatic load_len(input logic [15:0] len, input logic quad);
        counter_in     = len;
        en_quad_in     = quad;
        counter_in_upd = 1'b1;
        tick();
        counter_in_upd = 1'b0;
    endtask

    task automatic start_xfer();
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; en = 1'b0; rx_edge = 1'b0; data_ready = 1'b1;
        {sdi3, sdi2, sdi1, sdi0} = 4'h0;
        en_quad_in = 1'b0; counter_in = 16'd0; counter_in_upd = 1'b0;
        #22;
        checks++;
        if ({rx_done, data_valid, clk_en_o} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 000", {rx_done, data_valid, clk_en_o});
        end
        checks++;
        if (data !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: got %h expected 00000000", data);
        end
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_std32();
        logic [31:0] w;
        w = 32'hA5C3_0F96;
        load_len(16'd32, 1'b0);
        start_xfer();
        @(negedge clk);
        checks++;
        if ({clk_en_o, data_valid} !== 2'b10) begin
            failures++;
            $display("FAIL std32_receive_idle: ce,valid got %b expected 10", {clk_en_o, data_valid});
        end
        tick();
        for (int k = 1; k <= 32; k++) begin
            drive_edge(std_nib(w[32-k]), 1'b1);
            if (k < 32) begin
                checks++;
                if ({obs_valid, obs_done} !== 2'b00) begin
                    failures++;
                    $display("FAIL std32_edge%0d: valid,done got %b expected 00", k, {obs_valid, obs_done});
                end
            end else begin
                checks++;
                if ({obs_valid, obs_done, obs_data} !== {2'b11, w}) begin
                    failures++;
                    $display("FAIL std32_word: valid,done,data got %b %b %h expected 1 1 %h",
                             obs_valid, obs_done, obs_data, w);
                end
            end
        end
        @(negedge clk);
        checks++;
        if ({clk_en_o, data_valid} !== 2'b00) begin
            failures++;
            $display("FAIL std32_idle: ce,valid got %b expected 00", {clk_en_o, data_valid});
        end
        tick();
    endtask

    task automatic test_quad64();
        logic [63:0] s;
        s = 64'h1234_5678_9ABC_DEF0;
        load_len(16'd64, 1'b1);
        start_xfer();
        for (int k = 1; k <= 16; k++) begin
            drive_edge(s[64-4*k +: 4], 1'b1);
            if (k == 8) begin
                checks++;
                if ({obs_valid, obs_done, obs_data} !== {2'b10, 32'h1234_5678}) begin
                    failures++;
                    $display("FAIL quad_word0: valid,done,data got %b %b %h expected 1 0 12345678",
                             obs_valid, obs_done, obs_data);
                end
            end else if (k == 16) begin
                checks++;
                if ({obs_valid, obs_done, obs_data} !== {2'b11, 32'h9ABC_DEF0}) begin
                    failures++;
                    $display("FAIL quad_word1: valid,done,data got %b %b %h expected 1 1 9abcdef0",
                             obs_valid, obs_done, obs_data);
                end
            end else begin
                checks++;
                if ({obs_valid, obs_done} !== 2'b00) begin
                    failures++;
                    $display("FAIL quad_nib%0d: valid,done got %b expected 00", k, {obs_valid, obs_done});
                end
            end
        end
        @(negedge clk);
        checks++;
        if ({clk_en_o, data_valid} !== 2'b00) begin
            failures++;
            $display("FAIL quad_idle: ce,valid got %b expected 00", {clk_en_o, data_valid});
        end
        tick();
    endtask

    task automatic test_std12();
        logic [11:0] b;
        b = 12'hABC;
        load_len(16'd12, 1'b0);
        start_xfer();
        for (int k = 1; k <= 12; k++) begin
            drive_edge(std_nib(b[12-k]), 1'b1);
            if (k < 12) begin
                checks++;
                if ({obs_valid, obs_done} !== 2'b00) begin
                    failures++;
                    $display("FAIL std12_edge%0d: valid,done got %b expected 00", k, {obs_valid, obs_done});
                end
            end else begin
                checks++;
                if ({obs_valid, obs_done, obs_data} !== {2'b11, 32'h0000_0ABC}) begin
                    failures++;
                    $display("FAIL std12_word: valid,done,data got %b %b %h expected 1 1 00000abc",
                             obs_valid, obs_done, obs_data);
                end
            end
        end
        tick();
    endtask

    task automatic test_backpressure_mid();
        logic [31:0] w0;
        logic [31:0] w1;
        w0 = 32'hDEAD_BEEF;
        w1 = 32'h0F1E_2D3C;
        load_len(16'd64, 1'b0);
        start_xfer();
        for (int k = 1; k <= 31; k++) begin
            drive_edge(std_nib(w0[32-k]), 1'b1);
        end
        drive_edge(std_nib(w0[0]), 1'b0);
        checks++;
        if ({obs_valid, obs_done, obs_ce, obs_data} !== {3'b100, w0}) begin
            failures++;
            $display("FAIL bp_mid_boundary: valid,done,ce,data got %b%b%b %h expected 100 %h",
                     obs_valid, obs_done, obs_ce, obs_data, w0);
        end
        // Stall: stray edges and toggling lanes must not disturb the held word.
        for (int c = 0; c < 5; c++) begin
            rx_edge = (c == 1 || c == 3);
            {sdi3, sdi2, sdi1, sdi0} = (c[0]) ? 4'hF : 4'h0;
            data_ready = 1'b0;
            @(negedge clk);
            checks++;
            if ({data_valid, clk_en_o, rx_done, data} !== {3'b100, w0}) begin
                failures++;
                $display("FAIL bp_mid_stall%0d: valid,ce,done,data got %b%b%b %h expected 100 %h",
                         c, data_valid, clk_en_o, rx_done, data, w0);
            end
            tick();
        end
        rx_edge    = 1'b0;
        data_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({data_valid, clk_en_o, data} !== {2'b10, w0}) begin
            failures++;
            $display("FAIL bp_mid_accept: valid,ce,data got %b%b %h expected 10 %h",
                     data_valid, clk_en_o, data, w0);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({data_valid, clk_en_o} !== 2'b01) begin
            failures++;
            $display("FAIL bp_mid_resume: valid,ce got %b expected 01", {data_valid, clk_en_o});
        end
        tick();
        for (int k = 1; k <= 32; k++) begin
            drive_edge(std_nib(w1[32-k]), 1'b1);
        end
        checks++;
        if ({obs_valid, obs_done, obs_data} !== {2'b11, w1}) begin
            failures++;
            $display("FAIL bp_mid_word1: valid,done,data got %b %b %h expected 1 1 %h",
                     obs_valid, obs_done, obs_data, w1);
        end
        tick();
    endtask

    task automatic test_backpressure_done();
        logic [7:0] b;
        b = 8'h5A;
        load_len(16'd8, 1'b0);
        start_xfer();
        for (int k = 1; k <= 7; k++) begin
            drive_edge(std_nib(b[8-k]), 1'b1);
        end
        drive_edge(std_nib(b[0]), 1'b0);
        checks++;
        if ({obs_valid, obs_done, obs_ce, obs_data} !== {3'b110, 32'h0000_005A}) begin
            failures++;
            $display("FAIL bp_done_last: valid,done,ce,data got %b%b%b %h expected 110 0000005a",
                     obs_valid, obs_done, obs_ce, obs_data);
        end
        for (int c = 0; c < 3; c++) begin
            rx_edge    = (c == 1);
            data_ready = 1'b0;
            @(negedge clk);
            checks++;
            if ({data_valid, clk_en_o, rx_done, data} !== {3'b100, 32'h0000_005A}) begin
                failures++;
                $display("FAIL bp_done_stall%0d: valid,ce,done,data got %b%b%b %h expected 100 0000005a",
                         c, data_valid, clk_en_o, rx_done, data);
            end
            tick();
        end
        rx_edge    = 1'b0;
        data_ready = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if ({data_valid, clk_en_o} !== 2'b00) begin
            failures++;
            $display("FAIL bp_done_idle: valid,ce got %b expected 00", {data_valid, clk_en_o});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'hC3;
        load_len(16'd32, 1'b0);
        start_xfer();
        for (int k = 1; k <= 10; k++) begin
            drive_edge(std_nib(1'b1), 1'b1);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({rx_done, data_valid, clk_en_o, data} !== {3'b000, 32'h0}) begin
            failures++;
            $display("FAIL reset_mid_outputs: done,valid,ce,data got %b%b%b %h expected 000 00000000",
                     rx_done, data_valid, clk_en_o, data);
        end
        tick();
        rstn = 1'b1;
        tick();
        // No length update: the reset target of 8 bits must apply.
        start_xfer();
        for (int k = 1; k <= 8; k++) begin
            drive_edge(std_nib(b[8-k]), 1'b1);
            if (k < 8) begin
                checks++;
                if ({obs_valid, obs_done} !== 2'b00) begin
                    failures++;
                    $display("FAIL reset_mid_edge%0d: valid,done got %b expected 00", k, {obs_valid, obs_done});
                end
            end else begin
                checks++;
                if ({obs_valid, obs_done, obs_data} !== {2'b11, 32'h0000_00C3}) begin
                    failures++;
                    $display("FAIL reset_mid_word: valid,done,data got %b %b %h expected 1 1 000000c3",
                             obs_valid, obs_done, obs_data);
                end
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_std32();
        test_quad64();
        test_std12();
        test_backpressure_mid();
        test_backpressure_done();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
